// File: rtl/datapath_sequencer.sv
// Instruction sequencer for the 16-bit register-file datapath: latches one
// instruction per start strobe and steps the datapath through fetch/execute/write-back.
module datapath_sequencer (
    input  logic        clk,
    input  logic        reset,
    input  logic        s,
    input  logic [15:0] instr,
    output logic        w,
    output logic        illegal,
    output logic [15:0] datapath_in,
    output logic [2:0]  readnum,
    output logic [2:0]  writenum,
    output logic        write,
    output logic        vsel,
    output logic        loada,
    output logic        loadb,
    output logic        asel,
    output logic        bsel,
    output logic [1:0]  shift,
    output logic [1:0]  ALUop,
    output logic        loadc,
    output logic        loads
);

    localparam int unsigned DW   = 16;
    localparam int unsigned RW   = 3;
    localparam int unsigned IMMW = 8;

    typedef enum logic [2:0] {
        S_WAIT, S_DECODE, S_GET_A, S_GET_B, S_COMPUTE, S_WRITE_REG, S_WRITE_IMM
    } state_t;

    typedef struct packed {
        logic          w;
        logic          illegal;
        logic [DW-1:0] din;
        logic [RW-1:0] rnum;
        logic [RW-1:0] wnum;
        logic          write;
        logic          vsel;
        logic          loada;
        logic          loadb;
        logic          asel;
        logic          bsel;
        logic [1:0]    shift;
        logic [1:0]    aluop;
        logic          loadc;
        logic          loads;
    } ctl_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [DW-1:0]   r_ir;
    logic [DW-1:0]   w_ir_nxt;
    ctl_t            r_ctl;
    ctl_t            w_ctl;

    logic [2:0]      w_opcode;
    logic [1:0]      w_op;
    logic [RW-1:0]   w_rn, w_rd, w_rm;
    logic [1:0]      w_sh;
    logic [IMMW-1:0] w_imm8;
    logic            w_is_movi, w_is_movr, w_is_alu, w_is_mvn, w_is_cmp, w_legal;

    // IR only changes on the WAIT->DECODE edge; outputs decode from the IR about to be held.
    assign w_ir_nxt  = (r_state == S_WAIT && s) ? instr : r_ir;

    assign w_opcode  = w_ir_nxt[15:13];
    assign w_op      = w_ir_nxt[12:11];
    assign w_rn      = w_ir_nxt[10:8];
    assign w_rd      = w_ir_nxt[7:5];
    assign w_sh      = w_ir_nxt[4:3];
    assign w_rm      = w_ir_nxt[2:0];
    assign w_imm8    = w_ir_nxt[7:0];

    assign w_is_movi = (w_opcode == 3'b110) && (w_op == 2'b10);
    assign w_is_movr = (w_opcode == 3'b110) && (w_op == 2'b00);
    assign w_is_alu  = (w_opcode == 3'b101);
    assign w_is_mvn  = w_is_alu && (w_op == 2'b11);
    assign w_is_cmp  = w_is_alu && (w_op == 2'b01);
    assign w_legal   = w_is_movi || w_is_movr || w_is_alu;

    // Next-state decode
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_WAIT:      if (s) w_state_nxt = S_DECODE;
            S_DECODE: begin
                if (w_is_movi)                  w_state_nxt = S_WRITE_IMM;
                else if (w_is_movr || w_is_mvn) w_state_nxt = S_GET_B;
                else if (w_is_alu)              w_state_nxt = S_GET_A;
                else                            w_state_nxt = S_WAIT;
            end
            S_GET_A:     w_state_nxt = S_GET_B;
            S_GET_B:     w_state_nxt = S_COMPUTE;
            S_COMPUTE:   w_state_nxt = w_is_cmp ? S_WAIT : S_WRITE_REG;
            S_WRITE_REG: w_state_nxt = S_WAIT;
            S_WRITE_IMM: w_state_nxt = S_WAIT;
            default:     w_state_nxt = S_WAIT;
        endcase
    end

    // Controls for the state being entered, so the registered outputs are Moore in that state
    always_comb begin
        w_ctl = '0;
        unique case (w_state_nxt)
            S_WAIT:      w_ctl.w = 1'b1;
            S_DECODE:    w_ctl.illegal = !w_legal;
            S_GET_A: begin
                w_ctl.rnum  = w_rn;
                w_ctl.loada = 1'b1;
            end
            S_GET_B: begin
                w_ctl.rnum  = w_rm;
                w_ctl.loadb = 1'b1;
            end
            S_COMPUTE: begin
                w_ctl.shift = w_sh;
                w_ctl.loadc = 1'b1;
                w_ctl.aluop = w_is_movr ? 2'b00 : w_op;
                w_ctl.asel  = w_is_movr || w_is_mvn;
                w_ctl.loads = w_is_cmp;
            end
            S_WRITE_REG: begin
                w_ctl.wnum  = w_rd;
                w_ctl.write = 1'b1;
            end
            S_WRITE_IMM: begin
                w_ctl.wnum  = w_rn;
                w_ctl.vsel  = 1'b1;
                w_ctl.write = 1'b1;
                w_ctl.din   = {{(DW-IMMW){w_imm8[IMMW-1]}}, w_imm8};
            end
            default:     w_ctl = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_WAIT;
            r_ir    <= '0;
            r_ctl   <= '0;
            r_ctl.w <= 1'b1;
        end else begin
            r_state <= w_state_nxt;
            r_ir    <= w_ir_nxt;
            r_ctl   <= w_ctl;
        end
    end

    assign w           = r_ctl.w;
    assign illegal     = r_ctl.illegal;
    assign datapath_in = r_ctl.din;
    assign readnum     = r_ctl.rnum;
    assign writenum    = r_ctl.wnum;
    assign write       = r_ctl.write;
    assign vsel        = r_ctl.vsel;
    assign loada       = r_ctl.loada;
    assign loadb       = r_ctl.loadb;
    assign asel        = r_ctl.asel;
    assign bsel        = r_ctl.bsel;
    assign shift       = r_ctl.shift;
    assign ALUop       = r_ctl.aluop;
    assign loadc       = r_ctl.loadc;
    assign loads       = r_ctl.loads;

endmodule

// File: tb/tb_datapath_sequencer.sv
// Bench for datapath_sequencer: a behavioural datapath follows the sequencer's
// controls while a scoreboard of expected register writes is checked on each write pulse.
module tb_datapath_sequencer;

    logic        clk = 1'b0;
    logic        reset, s;
    logic [15:0] instr;
    logic        w, illegal, write, vsel, loada, loadb, asel, bsel, loadc, loads;
    logic [15:0] datapath_in;
    logic [2:0]  readnum, writenum;
    logic [1:0]  shift, ALUop;

    datapath_sequencer dut (
        .clk(clk), .reset(reset), .s(s), .instr(instr), .w(w), .illegal(illegal),
        .datapath_in(datapath_in), .readnum(readnum), .writenum(writenum),
        .write(write), .vsel(vsel), .loada(loada), .loadb(loadb), .asel(asel),
        .bsel(bsel), .shift(shift), .ALUop(ALUop), .loadc(loadc), .loads(loads)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;
    int start  = 0;
    int n_loada, n_loads, n_write, n_ill, loads_edge;

    typedef struct { int wnum; logic [15:0] data; int edge_n; } wr_t;
    wr_t sb[$];

    // Behavioural datapath driven by the sequencer
    logic [15:0] rf [8];
    logic [15:0] ra, rb, rc, bsh, ain, alu;
    logic        rz;

    initial begin
        for (int i = 0; i < 8; i++) rf[i] = 16'h0;
        ra = '0; rb = '0; rc = '0; rz = 1'b0;
    end

    always_comb begin
        case (shift)
            2'b01:   bsh = {rb[14:0], 1'b0};
            2'b10:   bsh = {1'b0, rb[15:1]};
            2'b11:   bsh = {rb[15], rb[15:1]};
            default: bsh = rb;
        endcase
        ain = asel ? 16'h0 : ra;
        case (ALUop)
            2'b00:   alu = ain + bsh;
            2'b01:   alu = ain - bsh;
            2'b10:   alu = ain & bsh;
            default: alu = ~bsh;
        endcase
    end

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (write) rf[writenum] <= vsel ? datapath_in : rc;
        if (loada) ra <= rf[readnum];
        if (loadb) rb <= rf[readnum];
        if (loadc) rc <= alu;
        if (loads) rz <= (alu == 16'h0);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Monitor: count control pulses and pop the scoreboard on every write
    always @(negedge clk) begin
        wr_t e;
        if (loada) n_loada++;
        if (illegal) n_ill++;
        if (loads) begin
            n_loads++;
            loads_edge = cyc + 1 - start;
        end
        if (write) begin
            n_write++;
            chk("write_expected", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("write_num", 32'(writenum), 32'(e.wnum));
                chk("write_data", 32'(vsel ? datapath_in : rc), 32'(e.data));
                chk("write_edge", 32'(cyc + 1 - start), 32'(e.edge_n));
            end
        end
    end

    task automatic push(input int wnum, input logic [15:0] data, input int edge_n);
        wr_t e;
        e.wnum = wnum; e.data = data; e.edge_n = edge_n;
        sb.push_back(e);
    endtask

    // Launch one instruction from a negedge in WAIT; glitch>0 pulses s in that busy cycle
    task automatic issue(input logic [15:0] ins, input int exp_low, input int glitch, input string tag);
        int low;
        low = 0;
        s = 1'b1; instr = ins;
        @(posedge clk);
        #1;
        start = cyc; s = 1'b0; instr = 16'h0;
        n_loada = 0; n_loads = 0; n_write = 0; n_ill = 0; loads_edge = -1;
        forever begin
            @(negedge clk);
            if (w) break;
            low++;
            if (low > 20) break;
            if (low == glitch) begin
                s = 1'b1; instr = 16'hD0FF;
            end else begin
                s = 1'b0;
            end
        end
        s = 1'b0;
        chk({tag, "_wlow"}, 32'(low), 32'(exp_low));
    endtask

    logic [29:0] all_ctl;
    assign all_ctl = {illegal, datapath_in, readnum, writenum, write, vsel, loada,
                      loadb, asel, bsel, shift, ALUop, loadc, loads};

    initial begin
        reset = 1'b1; s = 1'b0; instr = 16'h0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_w", 32'(w), 32'd1);
        chk("reset_ctl", 32'(all_ctl), 32'd0);
        reset = 1'b0;

        push(0, 16'h0007, 2); issue(16'hD007, 2, 0, "movi_r0");
        push(1, 16'hFF82, 2); issue(16'hD182, 2, 0, "movi_r1");
        chk("r0", 32'(rf[0]), 32'h0007);
        chk("r1", 32'(rf[1]), 32'hFF82);

        push(1, 16'h0002, 2); issue(16'hD102, 2, 0, "movi_r1b");
        push(2, 16'h0003, 2); issue(16'hD203, 2, 0, "movi_r2");
        push(3, 16'h0008, 5); issue(16'hA16A, 5, 0, "add");
        chk("add_r3", 32'(rf[3]), 32'h0008);
        chk("add_c", 32'(rc), 32'h0008);
        chk("add_z", 32'(rz), 32'd0);
        chk("add_loads", 32'(n_loads), 32'd0);

        push(4, 16'h0005, 2); issue(16'hD405, 2, 0, "movi_r4");
        push(5, 16'h0005, 2); issue(16'hD505, 2, 0, "movi_r5");
        issue(16'hAC05, 4, 0, "cmp");
        chk("cmp_z", 32'(rz), 32'd1);
        chk("cmp_loads", 32'(n_loads), 32'd1);
        chk("cmp_z_edge", 32'(loads_edge), 32'd4);
        chk("cmp_writes", 32'(n_write), 32'd0);

        push(6, 16'hFFF8, 4); issue(16'hB8C0, 4, 0, "mvn");
        chk("mvn_r6", 32'(rf[6]), 32'hFFF8);
        chk("mvn_loada", 32'(n_loada), 32'd0);
        push(7, 16'hFFF8, 4); issue(16'hC0E6, 4, 0, "movr");
        chk("movr_r7", 32'(rf[7]), 32'hFFF8);
        chk("movr_loada", 32'(n_loada), 32'd0);

        push(3, 16'h0000, 5); issue(16'hB664, 5, 0, "and");
        chk("and_r3", 32'(rf[3]), 32'h0000);
        chk("and_z_kept", 32'(rz), 32'd1);

        // Undefined opcode: one-cycle illegal pulse then straight back to WAIT
        s = 1'b1; instr = 16'hE000;
        @(posedge clk);
        #1;
        start = cyc; s = 1'b0; instr = 16'h0;
        @(negedge clk);
        chk("ill_pulse", 32'(illegal), 32'd1);
        chk("ill_w_low", 32'(w), 32'd0);
        chk("ill_no_ctl", 32'({loada, loadb, write, loadc, loads}), 32'd0);
        @(negedge clk);
        chk("ill_done", 32'(illegal), 32'd0);
        chk("ill_w_back", 32'(w), 32'd1);

        issue(16'hC800, 1, 0, "ill_op");
        chk("ill_op_pulses", 32'(n_ill), 32'd1);
        chk("ill_op_writes", 32'(n_write), 32'd0);

        // Reset during COMPUTE of ADD R2,R1,R1 aborts the write
        s = 1'b1; instr = 16'hA141;
        @(posedge clk);
        #1;
        start = cyc; s = 1'b0; instr = 16'h0; n_write = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("abort_in_compute", 32'(loadc), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        chk("abort_w", 32'(w), 32'd1);
        chk("abort_ctl", 32'(all_ctl), 32'd0);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        chk("abort_r2", 32'(rf[2]), 32'h0003);
        chk("abort_writes", 32'(n_write), 32'd0);

        // Strobe during GET_B of ADD R4,R1,R2 must be ignored
        push(4, 16'h0005, 5); issue(16'hA182, 5, 3, "glitch");
        chk("glitch_r4", 32'(rf[4]), 32'h0005);
        chk("glitch_writes", 32'(n_write), 32'd1);
        repeat (3) @(negedge clk);
        chk("glitch_idle_w", 32'(w), 32'd1);
        chk("glitch_r0", 32'(rf[0]), 32'h0007);

        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
